// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply, restoring divide, a one-cycle sign fix-up, and a result held until EX consumes it.
module ex_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_UNROLL  = 1,
    parameter int SUPPORT_DIV = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_src1,
    input  logic [XLEN-1:0] req_src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);
    localparam int N  = XLEN / MUL_UNROLL;
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    typedef logic [XLEN+MUL_UNROLL-1:0] part_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, valid_q, valid_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, rem_q, rem_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              s1, s2, sign1, sign2, div0, ovf, special, ge;
    logic [XLEN-1:0]   mag1, mag2, spec_res, quo, rem, fix_res;
    logic [XLEN:0]     shifted;
    part_t             sum;
    logic [2*XLEN-1:0] mul_acc, div_acc, prod;
    assign req_ready   = (state_q == IDLE) & ~flush;
    assign busy        = state_q != IDLE;
    assign resp_valid  = valid_q;
    assign resp_result = res_q;
    assign s1       = ~(req_op[0] & (req_op[1] | req_op[2]));
    assign s2       = req_op[2] ? ~req_op[0] : ~req_op[1];
    assign sign1    = s1 & req_src1[XLEN-1];
    assign sign2    = s2 & req_src2[XLEN-1];
    assign mag1     = sign1 ? -req_src1 : req_src1;
    assign mag2     = sign2 ? -req_src2 : req_src2;
    assign div0     = req_src2 == '0;
    assign ovf      = s2 & req_op[2] & (req_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&req_src2);
    assign special  = req_op[2] & ((SUPPORT_DIV == 0) | div0 | ovf);
    assign spec_res = (SUPPORT_DIV == 0) ? '0 : div0 ? (req_op[1] ? req_src1 : '1) : (req_op[1] ? '0 : req_src1);
    // Multiplier sits in the low half of acc and is shifted out as the product shifts in.
    assign sum      = part_t'(acc_q[2*XLEN-1:XLEN]) + part_t'(opnd_q) * part_t'(acc_q[MUL_UNROLL-1:0]);
    assign mul_acc  = {sum, acc_q[XLEN-1:MUL_UNROLL]};
    assign shifted  = {rem_q, acc_q[XLEN-1]};
    assign ge       = shifted >= {1'b0, opnd_q};
    assign div_acc  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ge};
    assign prod     = neg_res_q ? -acc_q : acc_q;
    assign quo      = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem      = neg_rem_q ? -rem_q : rem_q;
    assign fix_res  = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        res_d     = res_q;
        valid_d   = valid_q;
        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    op_d      = req_op;
                    neg_res_d = sign1 ^ sign2;
                    neg_rem_d = sign1;
                    cnt_d     = '0;
                    opnd_d    = req_op[2] ? mag2 : mag1;
                    acc_d     = {{XLEN{1'b0}}, req_op[2] ? mag1 : mag2};
                    rem_d     = '0;
                    state_d   = special ? DONE : (req_op[2] ? DIV : MUL);
                    res_d     = special ? spec_res : res_q;
                    valid_d   = special;
                end
                MUL: begin
                    acc_d   = mul_acc;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(N - 1)) ? FIX : MUL;
                end
                DIV: begin
                    acc_d   = div_acc;
                    rem_d   = ge ? XLEN'(shifted - {1'b0, opnd_q}) : XLEN'(shifted);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_q == CW'(XLEN - 1)) ? FIX : DIV;
                end
                FIX: begin
                    res_d   = fix_res;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                DONE: if (resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
        end
    end
endmodule
